// File: rtl/ksa4_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : ksa4_scoreboard
//  Purpose  : Result scoreboard downstream of the 4-bit Kogge-Stone adder.
//             Computes the golden sum of each issued operand word, delays it
//             by the adder latency and compares it against the captured
//             adder result. Keeps saturating check/error/spurious counters
//             and latches the first mismatch for debug.
//  Ports    : GCLK_Pad, rstn_Pad (async active-low), clear (sync flush)
//             op_valid, a, b, cin            - operand word issued to adder
//             res_sum, res_cout              - captured adder result
//             chk_valid, chk_ok              - one-cycle comparison strobe
//             chk_cnt, err_cnt, spur_cnt     - saturating statistics
//             first_err_valid/idx/exp/got    - first mismatch capture
//             idle                           - delay pipeline empty
//  Revision : 1.0 - initial release
// ============================================================================
module ksa4_scoreboard #(
   parameter int LATENCY = 3,
   parameter int CNT_W   = 16
) (
   input  logic             GCLK_Pad,
   input  logic             rstn_Pad,
   input  logic             clear,
   input  logic             op_valid,
   input  logic [3:0]       a,
   input  logic [3:0]       b,
   input  logic             cin,
   input  logic [3:0]       res_sum,
   input  logic             res_cout,
   output logic             chk_valid,
   output logic             chk_ok,
   output logic [CNT_W-1:0] chk_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] spur_cnt,
   output logic             first_err_valid,
   output logic [CNT_W-1:0] first_err_idx,
   output logic [4:0]       first_err_exp,
   output logic [4:0]       first_err_got,
   output logic             idle
);

   localparam logic [CNT_W-1:0] c_cnt_max = '1;
   localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

   // Delay line: stage 0 is loaded from the operand port, stage LATENCY-1
   // is the tail that lines up with the adder result on res_*.
   logic [LATENCY-1:0]      stg_v_q,   stg_v_d;
   logic [LATENCY-1:0][4:0] stg_exp_q, stg_exp_d;

   logic             chk_valid_q,       chk_valid_d;
   logic             chk_ok_q,          chk_ok_d;
   logic [CNT_W-1:0] chk_cnt_q,         chk_cnt_d;
   logic [CNT_W-1:0] err_cnt_q,         err_cnt_d;
   logic [CNT_W-1:0] spur_cnt_q,        spur_cnt_d;
   logic             first_err_valid_q, first_err_valid_d;
   logic [CNT_W-1:0] first_err_idx_q,   first_err_idx_d;
   logic [4:0]       first_err_exp_q,   first_err_exp_d;
   logic [4:0]       first_err_got_q,   first_err_got_d;

   logic [4:0] w_golden;
   logic [4:0] w_got;
   logic       w_tail_v;
   logic [4:0] w_tail_exp;
   logic       w_mismatch;
   logic       w_spurious;
   logic       w_err_event;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == c_cnt_max) ? v : v + c_cnt_one;
   endfunction

   assign w_golden    = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
   assign w_got       = {res_cout, res_sum};
   assign w_tail_v    = stg_v_q[LATENCY-1];
   assign w_tail_exp  = stg_exp_q[LATENCY-1];
   assign w_mismatch  = w_tail_v & (w_got != w_tail_exp);
   // Any pulse arriving in a bubble slot is an error, not a comparison.
   assign w_spurious  = ~w_tail_v & (w_got != 5'd0);
   assign w_err_event = w_mismatch | w_spurious;

   always_comb begin
      stg_v_d           = stg_v_q;
      stg_exp_d         = stg_exp_q;
      chk_valid_d       = 1'b0;
      chk_ok_d          = 1'b0;
      chk_cnt_d         = chk_cnt_q;
      err_cnt_d         = err_cnt_q;
      spur_cnt_d        = spur_cnt_q;
      first_err_valid_d = first_err_valid_q;
      first_err_idx_d   = first_err_idx_q;
      first_err_exp_d   = first_err_exp_q;
      first_err_got_d   = first_err_got_q;

      if (clear) begin
         // Flush wins over both the incoming operand and the tail result.
         stg_v_d           = '0;
         stg_exp_d         = '0;
         chk_cnt_d         = '0;
         err_cnt_d         = '0;
         spur_cnt_d        = '0;
         first_err_valid_d = 1'b0;
         first_err_idx_d   = '0;
         first_err_exp_d   = 5'd0;
         first_err_got_d   = 5'd0;
      end else begin
         stg_v_d[0]   = op_valid;
         stg_exp_d[0] = op_valid ? w_golden : 5'd0;
         for (int i = 1; i < LATENCY; i++) begin
            stg_v_d[i]   = stg_v_q[i-1];
            stg_exp_d[i] = stg_exp_q[i-1];
         end

         chk_valid_d = w_tail_v;
         chk_ok_d    = w_tail_v & ~w_mismatch;

         if (w_tail_v) begin
            chk_cnt_d = sat_inc(chk_cnt_q);
         end
         if (w_spurious) begin
            spur_cnt_d = sat_inc(spur_cnt_q);
         end
         if (w_err_event) begin
            err_cnt_d = sat_inc(err_cnt_q);
            // Index is the pre-increment check count, i.e. 0-based.
            if (!first_err_valid_q) begin
               first_err_valid_d = 1'b1;
               first_err_idx_d   = chk_cnt_q;
               first_err_exp_d   = w_tail_v ? w_tail_exp : 5'd0;
               first_err_got_d   = w_got;
            end
         end
      end
   end

   always_ff @(posedge GCLK_Pad or negedge rstn_Pad) begin
      if (!rstn_Pad) begin
         stg_v_q           <= '0;
         stg_exp_q         <= '0;
         chk_valid_q       <= 1'b0;
         chk_ok_q          <= 1'b0;
         chk_cnt_q         <= '0;
         err_cnt_q         <= '0;
         spur_cnt_q        <= '0;
         first_err_valid_q <= 1'b0;
         first_err_idx_q   <= '0;
         first_err_exp_q   <= 5'd0;
         first_err_got_q   <= 5'd0;
      end else begin
         stg_v_q           <= stg_v_d;
         stg_exp_q         <= stg_exp_d;
         chk_valid_q       <= chk_valid_d;
         chk_ok_q          <= chk_ok_d;
         chk_cnt_q         <= chk_cnt_d;
         err_cnt_q         <= err_cnt_d;
         spur_cnt_q        <= spur_cnt_d;
         first_err_valid_q <= first_err_valid_d;
         first_err_idx_q   <= first_err_idx_d;
         first_err_exp_q   <= first_err_exp_d;
         first_err_got_q   <= first_err_got_d;
      end
   end

   assign chk_valid       = chk_valid_q;
   assign chk_ok          = chk_ok_q;
   assign chk_cnt         = chk_cnt_q;
   assign err_cnt         = err_cnt_q;
   assign spur_cnt        = spur_cnt_q;
   assign first_err_valid = first_err_valid_q;
   assign first_err_idx   = first_err_idx_q;
   assign first_err_exp   = first_err_exp_q;
   assign first_err_got   = first_err_got_q;
   assign idle            = ~|stg_v_q;

endmodule
`default_nettype wire

// File: tb/tb_ksa4_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ksa4_scoreboard
//  Purpose  : Self-checking bench for ksa4_scoreboard. One instance with the
//             default counter width, one with 4-bit counters sharing the same
//             stimulus for saturation behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ksa4_scoreboard;

   localparam int LATENCY = 3;
   localparam int CNT_W   = 16;
   localparam int SAT_W   = 4;

   logic clk  = 1'b0;
   logic rstn = 1'b1;
   logic       clear, op_valid, cin, res_cout;
   logic [3:0] a, b, res_sum;

   logic             u0_chk_valid, u0_chk_ok, u0_fev, u0_idle;
   logic [CNT_W-1:0] u0_chk_cnt, u0_err_cnt, u0_spur_cnt, u0_fidx;
   logic [4:0]       u0_fexp, u0_fgot;

   logic             s_chk_valid, s_chk_ok, s_fev, s_idle;
   logic [SAT_W-1:0] s_chk_cnt, s_err_cnt, s_spur_cnt, s_fidx;
   logic [4:0]       s_fexp, s_fgot;

   always #5 clk = ~clk;

   ksa4_scoreboard #(.LATENCY(LATENCY), .CNT_W(CNT_W)) u0 (
      .GCLK_Pad(clk), .rstn_Pad(rstn), .clear(clear), .op_valid(op_valid),
      .a(a), .b(b), .cin(cin), .res_sum(res_sum), .res_cout(res_cout),
      .chk_valid(u0_chk_valid), .chk_ok(u0_chk_ok), .chk_cnt(u0_chk_cnt),
      .err_cnt(u0_err_cnt), .spur_cnt(u0_spur_cnt), .first_err_valid(u0_fev),
      .first_err_idx(u0_fidx), .first_err_exp(u0_fexp), .first_err_got(u0_fgot),
      .idle(u0_idle)
   );

   ksa4_scoreboard #(.LATENCY(LATENCY), .CNT_W(SAT_W)) u1 (
      .GCLK_Pad(clk), .rstn_Pad(rstn), .clear(clear), .op_valid(op_valid),
      .a(a), .b(b), .cin(cin), .res_sum(res_sum), .res_cout(res_cout),
      .chk_valid(s_chk_valid), .chk_ok(s_chk_ok), .chk_cnt(s_chk_cnt),
      .err_cnt(s_err_cnt), .spur_cnt(s_spur_cnt), .first_err_valid(s_fev),
      .first_err_idx(s_fidx), .first_err_exp(s_fexp), .first_err_got(s_fgot),
      .idle(s_idle)
   );

   // ---------------- reference model (event level) ----------------
   // Only valid operands are kept, tagged with their issue edge number; one
   // becomes due for comparison exactly LATENCY edges after it was issued.
   typedef struct {
      int         t_issue;
      logic [4:0] e;
   } pend_t;

   pend_t       pq[$];
   int          m_edge = 0;
   int unsigned m_chk, m_err, m_spur, m_fidx;
   bit          m_fev, m_cv, m_ok;
   logic [4:0]  m_fexp, m_fgot;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] sat(input int unsigned v, input int w);
      logic [31:0] mx;
      mx = (32'd1 << w) - 32'd1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_reset();
      pq.delete();
      m_chk = 0; m_err = 0; m_spur = 0; m_fidx = 0;
      m_fev = 1'b0; m_cv = 1'b0; m_ok = 1'b0;
      m_fexp = 5'd0; m_fgot = 5'd0;
   endtask

   task automatic note_err(input logic [4:0] e, input logic [4:0] g);
      if (!m_fev) begin
         m_fev  = 1'b1;
         m_fidx = m_chk;
         m_fexp = e;
         m_fgot = g;
      end
      m_err++;
   endtask

   function automatic bit tail_due();
      return (pq.size() > 0) && (pq[0].t_issue == m_edge - LATENCY);
   endfunction

   task automatic model_edge(input bit ov, input logic [4:0] sum, input bit clr,
                             input logic [4:0] res);
      bit         tv;
      logic [4:0] te;
      if (clr) begin
         model_reset();
      end else begin
         tv = 1'b0;
         te = 5'd0;
         if (tail_due()) begin
            tv = 1'b1;
            te = pq[0].e;
            void'(pq.pop_front());
         end
         m_cv = tv;
         m_ok = 1'b0;
         if (tv) begin
            m_ok = (res == te);
            if (!m_ok) note_err(te, res);
            m_chk++;
         end else if (res != 5'd0) begin
            m_spur++;
            note_err(5'd0, res);
         end
         if (ov) pq.push_back('{m_edge, sum});
      end
      m_edge++;
   endtask

   task automatic check_all();
      chk("chk_valid", 32'(u0_chk_valid), 32'(m_cv));
      if (m_cv) chk("chk_ok", 32'(u0_chk_ok), 32'(m_ok));
      chk("chk_cnt",  32'(u0_chk_cnt),  sat(m_chk,  CNT_W));
      chk("err_cnt",  32'(u0_err_cnt),  sat(m_err,  CNT_W));
      chk("spur_cnt", 32'(u0_spur_cnt), sat(m_spur, CNT_W));
      chk("first_err_valid", 32'(u0_fev), 32'(m_fev));
      chk("first_err_idx", 32'(u0_fidx), sat(m_fidx, CNT_W));
      chk("first_err_exp", 32'(u0_fexp), 32'(m_fexp));
      chk("first_err_got", 32'(u0_fgot), 32'(m_fgot));
      chk("idle", 32'(u0_idle), 32'(pq.size() == 0));
      chk("s_chk_valid", 32'(s_chk_valid), 32'(m_cv));
      if (m_cv) chk("s_chk_ok", 32'(s_chk_ok), 32'(m_ok));
      chk("s_chk_cnt",  32'(s_chk_cnt),  sat(m_chk,  SAT_W));
      chk("s_err_cnt",  32'(s_err_cnt),  sat(m_err,  SAT_W));
      chk("s_spur_cnt", 32'(s_spur_cnt), sat(m_spur, SAT_W));
      chk("s_first_err_valid", 32'(s_fev), 32'(m_fev));
      chk("s_first_err_idx", 32'(s_fidx), sat(m_fidx, SAT_W));
      chk("s_first_err_exp", 32'(s_fexp), 32'(m_fexp));
      chk("s_first_err_got", 32'(s_fgot), 32'(m_fgot));
      chk("s_idle", 32'(s_idle), 32'(pq.size() == 0));
   endtask

   // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
   task automatic step(input bit ov, input logic [3:0] ia, input logic [3:0] ib,
                       input bit ic, input bit clr, input logic [4:0] res);
      op_valid = ov; a = ia; b = ib; cin = ic; clear = clr;
      {res_cout, res_sum} = res;
      @(posedge clk);
      model_edge(ov, 5'(int'(ia) + int'(ib) + int'(ic)), clr, res);
      #1;
      check_all();
   endtask

   // Like step, but the adder result is the correct tail value XOR mask
   // (a nonzero mask in a bubble slot produces a spurious pulse).
   task automatic step_auto(input bit ov, input logic [3:0] ia, input logic [3:0] ib,
                            input bit ic, input bit clr, input logic [4:0] mask);
      logic [4:0] res;
      res = tail_due() ? (pq[0].e ^ mask) : mask;
      step(ov, ia, ib, ic, clr, res);
   endtask

   task automatic do_reset();
      #2 rstn = 1'b0;
      #1;
      model_reset();
      check_all();
      repeat (2) @(posedge clk);
      #1 check_all();
      @(negedge clk);
      rstn = 1'b1;
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       cin;
      logic [4:0] res;
      logic       ok;
   } vec_t;

   vec_t tbl[8];

   task automatic run_group(input int base);
      int         j;
      int         first_cv;
      logic [4:0] r;
      first_cv = -1;
      for (int i = 0; i < 4 + LATENCY + 1; i++) begin
         j = i - LATENCY;
         r = (j >= 0 && j < 4) ? tbl[base + j].res : 5'd0;
         if (i < 4) step(1'b1, tbl[base + i].a, tbl[base + i].b, tbl[base + i].cin, 1'b0, r);
         else       step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, r);
         if (u0_chk_valid && first_cv < 0) first_cv = i;
         if (j >= 0 && j < 4) begin
            chk("dir_valid", 32'(u0_chk_valid), 32'd1);
            chk("dir_ok", 32'(u0_chk_ok), 32'(tbl[base + j].ok));
         end
      end
      chk("first_chk_valid_latency", 32'(first_cv), 32'(LATENCY));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit         r_ov, r_clr;
      logic [3:0] r_a, r_b;
      bit         r_cin;
      logic [4:0] r_mask;

      tbl[0] = '{4'd2,  4'd3, 1'b0, 5'b00101, 1'b1};
      tbl[1] = '{4'd6,  4'd1, 1'b0, 5'b00111, 1'b1};
      tbl[2] = '{4'd7,  4'd4, 1'b1, 5'b01100, 1'b1};
      tbl[3] = '{4'd13, 4'd6, 1'b0, 5'b10011, 1'b1};
      tbl[4] = '{4'd2,  4'd3, 1'b0, 5'b00101, 1'b1};
      tbl[5] = '{4'd6,  4'd1, 1'b0, 5'b00111, 1'b1};
      tbl[6] = '{4'd7,  4'd4, 1'b1, 5'b01000, 1'b0};
      tbl[7] = '{4'd13, 4'd6, 1'b0, 5'b10011, 1'b1};

      clear = 1'b0; op_valid = 1'b0; a = 4'd0; b = 4'd0; cin = 1'b0;
      res_sum = 4'd0; res_cout = 1'b0;
      model_reset();

      // Reset, then 20 quiet cycles.
      do_reset();
      for (int i = 0; i < 20; i++) step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 5'd0);

      // Four correct back-to-back words.
      run_group(0);
      chk("pass_chk_cnt", 32'(u0_chk_cnt), 32'd4);
      chk("pass_err_cnt", 32'(u0_err_cnt), 32'd0);

      // Same words, third result corrupted.
      step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 5'd0);
      run_group(4);
      chk("corrupt_err_cnt", 32'(u0_err_cnt), 32'd1);
      chk("corrupt_chk_cnt", 32'(u0_chk_cnt), 32'd4);
      chk("corrupt_first_idx", 32'(u0_fidx), 32'd2);
      chk("corrupt_first_exp", 32'(u0_fexp), 32'b01100);
      chk("corrupt_first_got", 32'(u0_fgot), 32'b01000);

      // A second corruption must not disturb the first-error capture.
      step_auto(1'b1, 4'd1, 4'd1, 1'b0, 1'b0, 5'd0);
      for (int i = 0; i < LATENCY; i++)
         step_auto(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, (i == LATENCY - 1) ? 5'b10000 : 5'd0);
      chk("second_err_cnt", 32'(u0_err_cnt), 32'd2);
      chk("second_first_idx", 32'(u0_fidx), 32'd2);
      chk("second_first_exp", 32'(u0_fexp), 32'b01100);
      chk("second_first_got", 32'(u0_fgot), 32'b01000);

      // Spurious pulse in a bubble slot.
      step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 5'd0);
      step_auto(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 5'd0);
      step_auto(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 5'b00010);
      chk("spur_spur_cnt", 32'(u0_spur_cnt), 32'd1);
      chk("spur_err_cnt", 32'(u0_err_cnt), 32'd1);
      chk("spur_chk_cnt", 32'(u0_chk_cnt), 32'd0);
      chk("spur_chk_valid", 32'(u0_chk_valid), 32'd0);
      chk("spur_first_exp", 32'(u0_fexp), 32'd0);
      chk("spur_first_got", 32'(u0_fgot), 32'b00010);

      // Clear coinciding with an op_valid while two operands are in flight.
      step_auto(1'b1, 4'd3, 4'd4, 1'b0, 1'b0, 5'd0);
      step_auto(1'b1, 4'd5, 4'd5, 1'b1, 1'b0, 5'd0);
      step_auto(1'b1, 4'd9, 4'd9, 1'b0, 1'b1, 5'd0);
      chk("clear_chk_cnt", 32'(u0_chk_cnt), 32'd0);
      chk("clear_err_cnt", 32'(u0_err_cnt), 32'd0);
      chk("clear_spur_cnt", 32'(u0_spur_cnt), 32'd0);
      chk("clear_first_valid", 32'(u0_fev), 32'd0);
      chk("clear_idle", 32'(u0_idle), 32'd1);
      for (int i = 0; i < LATENCY + 2; i++) begin
         step_auto(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 5'd0);
         chk("flush_no_valid", 32'(u0_chk_valid), 32'd0);
      end

      // Reset in the middle of traffic.
      step_auto(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 5'b00100);
      step_auto(1'b1, 4'd2, 4'd2, 1'b0, 1'b0, 5'd0);
      step_auto(1'b1, 4'd3, 4'd3, 1'b0, 1'b0, 5'd0);
      do_reset();
      for (int i = 0; i < LATENCY + 1; i++) step_auto(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 5'd0);

      // Randomized traffic with occasional corruption, spurious pulses and clears.
      for (int n = 0; n < 400; n++) begin
         r_ov   = ($urandom_range(0, 3) != 0);
         r_a    = 4'($urandom);
         r_b    = 4'($urandom);
         r_cin  = 1'($urandom);
         r_clr  = ($urandom_range(0, 59) == 0);
         r_mask = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
         step_auto(r_ov, r_a, r_b, r_cin, r_clr, r_mask);
      end

      // Saturation: 20 mismatching checks.
      step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 5'd0);
      for (int i = 0; i < 20 + LATENCY; i++)
         step_auto(i < 20, 4'd15, 4'd15, 1'b1, 1'b0, tail_due() ? 5'b00001 : 5'd0);
      chk("sat_s_err_cnt", 32'(s_err_cnt), 32'd15);
      chk("sat_s_chk_cnt", 32'(s_chk_cnt), 32'd15);
      chk("sat_s_spur_cnt", 32'(s_spur_cnt), 32'd0);
      chk("sat_u0_err_cnt", 32'(u0_err_cnt), 32'd20);
      chk("sat_u0_chk_cnt", 32'(u0_chk_cnt), 32'd20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
